// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO: frames queued words as start, data (LSB first),
// optional parity and stop bits at CLK_FREQ_HZ/BAUD cycles per bit, back-to-back when queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 40_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          io_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 io_tx_q, io_tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 push, pop, bit_end;
  logic [DATA_BITS-1:0] head;

  // Next-state for the frame sequencer, FIFO pointers and registered outputs
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pop     = 1'b0;
    head    = mem_q[rptr_q];
    push    = wr_valid && ready_q;
    bit_end = (baud_q == CNT_W'(BAUD_DIV - 1));

    if (state_q == IDLE) baud_d = '0;
    else                 baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when a word is already waiting
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ (PARITY == 1);
      idx_d   = '0;
      rptr_d  = rptr_q + 1'b1;
    end
    if (push) wptr_d = wptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ready_d = (count_d < CW'(FIFO_DEPTH));
    busy_d  = (state_q != IDLE) || (count_q != '0);

    // Line follows the sequencer one cycle later
    case (state_q)
      START:   io_tx_d = 1'b0;
      DATA:    io_tx_d = shift_q[0];
      PAR:     io_tx_d = par_q;
      default: io_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      io_tx_q <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      io_tx_q <= io_tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign wr_ready   = ready_q;
  assign io_tx      = io_tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule
